// File: rtl/spi_wr_arbiter.sv
// Round-robin arbiter sharing the SPI write queue and SPI processor.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN.
`ifndef SUCCESS
`define SUCCESS 8'h00
`endif
`ifndef ERR_UNKNOWN_SPI_ARB_STATE
`define ERR_UNKNOWN_SPI_ARB_STATE 8'hE1
`endif
`ifndef ERR_SPI_ARB_TIMEOUT
`define ERR_SPI_ARB_TIMEOUT 8'hE2
`endif

module spi_wr_arbiter #(
  parameter int          NREQ         = 4,
  parameter logic [15:0] TIMEOUT_CLKS = 16'd4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] cmd_i,
  output logic [NREQ-1:0]   grant_o,
  output logic [NREQ-1:0]   done_o,
  output logic [7:0]        spiwr_queue_data_o,
  output logic              spiwr_queue_wr_en_o,
  input  logic              spiwr_queue_fifo_full_i,
  input  logic              spiwr_queue_wr_ack_i,
  input  logic              spi_processor_idle,
  output logic [7:0]        status_o,
  output logic              busy_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_QUEUE,
    ARB_ACK_WAIT,
    ARB_START_WAIT,
    ARB_FINISH_WAIT,
    ARB_RELEASE
  } arb_state_t;

  arb_state_t      state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   gnt_idx;
  logic [7:0]      cmd_q;

  logic            pick_ok;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] pick_oh;
  logic [7:0]      pick_cmd;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]     wdog;
  logic            tmo;
`else
  if (TIMEOUT_CLKS == 16'd0) begin : g_no_wdog
  end
`endif

  // Search upward from the slot after the last owner, wrapping at NREQ.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NREQ);
      if (!pick_ok && req_i[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    pick_oh  = '0;
    pick_cmd = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IW'(k) == pick_idx) begin
        pick_oh[k] = 1'b1;
        pick_cmd   = cmd_i[k*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= ARB_IDLE;
      grant_o             <= '0;
      done_o              <= '0;
      spiwr_queue_data_o  <= '0;
      spiwr_queue_wr_en_o <= 1'b0;
      status_o            <= `SUCCESS;
      busy_o              <= 1'b0;
      last_grant          <= IW'(NREQ - 1);
      gnt_idx             <= '0;
      cmd_q               <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog                <= '0;
      tmo                 <= 1'b0;
`endif
    end else if (arb_en) begin
      case (state)
        ARB_IDLE: begin
          busy_o <= 1'b0;
          done_o <= '0;
          if (pick_ok && spi_processor_idle) begin
            grant_o <= pick_oh;
            gnt_idx <= pick_idx;
            cmd_q   <= pick_cmd;
            busy_o  <= 1'b1;
            state   <= ARB_QUEUE;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo     <= 1'b0;
`endif
          end
        end
        ARB_QUEUE: begin
          if (!spiwr_queue_fifo_full_i) begin
            spiwr_queue_data_o  <= cmd_q;
            spiwr_queue_wr_en_o <= 1'b1;
            state               <= ARB_ACK_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            wdog                <= TIMEOUT_CLKS;
`endif
          end
        end
        ARB_ACK_WAIT: begin
          if (spiwr_queue_wr_ack_i) begin
            spiwr_queue_wr_en_o <= 1'b0;
            state               <= ARB_START_WAIT;
          end
        end
        ARB_START_WAIT: begin
          if (!spi_processor_idle)
            state <= ARB_FINISH_WAIT;
        end
        ARB_FINISH_WAIT: begin
          if (spi_processor_idle)
            state <= ARB_RELEASE;
        end
        ARB_RELEASE: begin
          done_o     <= grant_o;
          last_grant <= gnt_idx;
          grant_o    <= '0;
          busy_o     <= 1'b0;
          state      <= ARB_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
          status_o   <= tmo ? `ERR_SPI_ARB_TIMEOUT : `SUCCESS;
`else
          status_o   <= `SUCCESS;
`endif
        end
        default: begin
          status_o            <= `ERR_UNKNOWN_SPI_ARB_STATE;
          grant_o             <= '0;
          spiwr_queue_wr_en_o <= 1'b0;
          busy_o              <= 1'b0;
          state               <= ARB_IDLE;
        end
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      // Expiry overrides any transition taken above this clock.
      if (state inside {ARB_ACK_WAIT, ARB_START_WAIT, ARB_FINISH_WAIT}) begin
        if (wdog == 16'd0) begin
          spiwr_queue_wr_en_o <= 1'b0;
          status_o            <= `ERR_SPI_ARB_TIMEOUT;
          tmo                 <= 1'b1;
          state               <= ARB_RELEASE;
        end else begin
          wdog <= wdog - 16'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_wr_arbiter.sv
// Scoreboard bench for spi_wr_arbiter.
// Covers reset, round-robin, fifo full, abort, freeze and watchdog.
module tb_spi_wr_arbiter;

  localparam int NREQ = 4;
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_TMO = 8'hE2;

  logic              clk = 1'b0;
  logic              rst;
  logic              arb_en;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] cmd;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        qdata;
  logic              wr_en;
  logic              full;
  logic              ack;
  logic              idle;
  logic [7:0]        status;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  int n_dones  = 0;
  logic wr_d = 1'b0;

  logic [7:0] exp_cmd_q[$];
  int         exp_gnt_q[$];

  spi_wr_arbiter #(
    .NREQ(NREQ),
    .TIMEOUT_CLKS(16'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb_en(arb_en),
    .req_i(req),
    .cmd_i(cmd),
    .grant_o(grant),
    .done_o(done),
    .spiwr_queue_data_o(qdata),
    .spiwr_queue_wr_en_o(wr_en),
    .spiwr_queue_fifo_full_i(full),
    .spiwr_queue_wr_ack_i(ack),
    .spi_processor_idle(idle),
    .status_o(status),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wr_d <= wr_en;
    if (wr_en && !wr_d) n_writes++;
    if (|done) n_dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    arb_en = 1'b1;
    req = '0;
    cmd = '0;
    full = 1'b0;
    ack = 1'b0;
    idle = 1'b1;
    exp_cmd_q.delete();
    exp_gnt_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic expect_txn(input int k, input logic [7:0] c);
    cmd[k*8 +: 8] = c;
    exp_cmd_q.push_back(c);
    exp_gnt_q.push_back(k);
  endtask

  task automatic serve_queue(output bit ok);
    int t;
    logic [7:0] ec;
    logic [NREQ-1:0] eoh;
    t = 0;
    ok = 1'b0;
    while (!wr_en && t < 40) begin
      tick();
      t++;
    end
    n_tests++;
    if (wr_en !== 1'b1) begin
      $display("FAIL queue_write_wait: wr_en=%b after %0d clks, required 1", wr_en, t);
      n_fail++;
      return;
    end
    ec = exp_cmd_q.pop_front();
    eoh = '0;
    eoh[exp_gnt_q[0]] = 1'b1;
    n_tests++;
    if (qdata !== ec) begin
      $display("FAIL queue_data: got %h, required %h", qdata, ec);
      n_fail++;
    end
    n_tests++;
    if (grant !== eoh) begin
      $display("FAIL grant: got %b, required %b", grant, eoh);
      n_fail++;
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_tests++;
    if (wr_en !== 1'b0) begin
      $display("FAIL wr_en_drop: got %b, required 0", wr_en);
      n_fail++;
    end
    ok = 1'b1;
  endtask

  task automatic serve_finish(input int start_dly, input int busy_len,
                              input logic [NREQ-1:0] raise,
                              input logic [7:0] est);
    int t;
    int eg;
    logic [NREQ-1:0] eoh;
    repeat (start_dly) tick();
    idle = 1'b0;
    req = req | raise;
    repeat (busy_len) tick();
    idle = 1'b1;
    t = 0;
    while (done === '0 && t < 6) begin
      tick();
      t++;
    end
    eg = exp_gnt_q.pop_front();
    eoh = '0;
    eoh[eg] = 1'b1;
    n_tests++;
    if (done !== eoh || t != 2) begin
      $display("FAIL done_pulse: got %b after %0d clks, required %b after 2", done, t, eoh);
      n_fail++;
    end
    n_tests++;
    if (status !== est) begin
      $display("FAIL status: got %h, required %h", status, est);
      n_fail++;
    end
    n_tests++;
    if (busy !== 1'b0 || grant !== '0) begin
      $display("FAIL release: busy=%b grant=%b, required 0 and 0", busy, grant);
      n_fail++;
    end
    req[eg] = 1'b0;
    tick();
    n_tests++;
    if (done !== '0) begin
      $display("FAIL done_clear: got %b, required 0", done);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    arb_en = 1'b1;
    req = '0;
    cmd = '0;
    full = 1'b0;
    ack = 1'b0;
    idle = 1'b1;
    #3;
    n_tests++;
    if (grant !== '0 || done !== '0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_ctl: grant=%b done=%b wr_en=%b busy=%b, required all 0",
               grant, done, wr_en, busy);
      n_fail++;
    end
    n_tests++;
    if (status !== ST_OK || qdata !== 8'h00) begin
      $display("FAIL reset_data: status=%h data=%h, required %h and 00", status, qdata, ST_OK);
      n_fail++;
    end
  endtask

  task automatic test_single();
    bit ok;
    int w0;
    do_reset();
    w0 = n_writes;
    expect_txn(2, 8'h05);
    req = 4'b0100;
    serve_queue(ok);
    if (ok) serve_finish(3, 10, '0, ST_OK);
    n_tests++;
    if (n_writes - w0 != 1) begin
      $display("FAIL single_writes: got %0d writes, required 1", n_writes - w0);
      n_fail++;
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    expect_txn(0, 8'hA0);
    expect_txn(1, 8'hA1);
    expect_txn(3, 8'hA3);
    expect_txn(0, 8'hB0);
    cmd[7:0] = 8'hA0;
    req = 4'b1011;
    serve_queue(ok);
    if (ok) serve_finish(1, 3, '0, ST_OK);
    serve_queue(ok);
    if (ok) serve_finish(1, 3, '0, ST_OK);
    serve_queue(ok);
    cmd[7:0] = 8'hB0;
    if (ok) serve_finish(1, 3, 4'b0001, ST_OK);
    serve_queue(ok);
    if (ok) serve_finish(1, 3, '0, ST_OK);
    n_tests++;
    if (exp_gnt_q.size() != 0) begin
      $display("FAIL rr_leftover: %0d grants pending, required 0", exp_gnt_q.size());
      n_fail++;
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int w0;
    int viol;
    do_reset();
    full = 1'b1;
    w0 = n_writes;
    expect_txn(0, 8'h3C);
    req = 4'b0001;
    tick();
    n_tests++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      $display("FAIL full_grant: grant=%b busy=%b, required 0001 and 1", grant, busy);
      n_fail++;
    end
    viol = 0;
    repeat (20) begin
      tick();
      if (wr_en !== 1'b0) viol++;
    end
    n_tests++;
    if (viol != 0) begin
      $display("FAIL full_hold: wr_en high %0d clks, required 0", viol);
      n_fail++;
    end
    full = 1'b0;
    serve_queue(ok);
    if (ok) serve_finish(2, 4, '0, ST_OK);
    n_tests++;
    if (n_writes - w0 != 1) begin
      $display("FAIL full_writes: got %0d writes, required 1", n_writes - w0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    do_reset();
    expect_txn(0, 8'h11);
    req = 4'b0001;
    serve_queue(ok);
    if (ok) serve_finish(1, 2, '0, ST_OK);
    expect_txn(1, 8'h22);
    req = 4'b0010;
    serve_queue(ok);
    void'(exp_gnt_q.pop_front());
    tick();
    idle = 1'b0;
    repeat (2) tick();
    #2;
    d0 = n_dones;
    rst = 1'b0;
    #1;
    n_tests++;
    if (grant !== '0 || wr_en !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort_async: grant=%b wr_en=%b busy=%b, required all 0", grant, wr_en, busy);
      n_fail++;
    end
    repeat (3) tick();
    n_tests++;
    if (n_dones != d0 || done !== '0) begin
      $display("FAIL abort_done: got %0d pulses, required 0", n_dones - d0);
      n_fail++;
    end
    rst = 1'b1;
    idle = 1'b1;
    expect_txn(0, 8'h33);
    expect_txn(1, 8'h22);
    req = 4'b0011;
    serve_queue(ok);
    if (ok) serve_finish(1, 2, '0, ST_OK);
    serve_queue(ok);
    if (ok) serve_finish(1, 2, '0, ST_OK);
  endtask

  task automatic test_arb_en();
    bit ok;
    int viol;
    logic [NREQ-1:0] g;
    logic [7:0] s;
    do_reset();
    expect_txn(2, 8'h77);
    req = 4'b0100;
    serve_queue(ok);
    arb_en = 1'b0;
    g = grant;
    s = status;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      idle = ~idle;
      tick();
      if (grant !== g || busy !== 1'b1 || wr_en !== 1'b0 ||
          done !== '0 || status !== s) viol++;
    end
    n_tests++;
    if (viol != 0 || g !== 4'b0100) begin
      $display("FAIL freeze: %0d changed clks, grant=%b, required 0 and 0100", viol, g);
      n_fail++;
    end
    arb_en = 1'b1;
    idle = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (done !== '0 || busy !== 1'b1) begin
      $display("FAIL resume_wait: done=%b busy=%b, required 0000 and 1", done, busy);
      n_fail++;
    end
    if (ok) serve_finish(0, 4, '0, ST_OK);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int t;
    do_reset();
    expect_txn(1, 8'h99);
    req = 4'b0010;
    serve_queue(ok);
    t = 0;
    while (done === '0 && t < 40) begin
      tick();
      t++;
    end
    void'(exp_gnt_q.pop_front());
    n_tests++;
    if (done !== 4'b0010 || t != 17) begin
      $display("FAIL tmo_done: got %b after %0d clks, required 0010 after 17", done, t);
      n_fail++;
    end
    n_tests++;
    if (status !== ST_TMO) begin
      $display("FAIL tmo_status: got %h, required %h", status, ST_TMO);
      n_fail++;
    end
    req = '0;
    tick();
    expect_txn(2, 8'h5A);
    req = 4'b0100;
    serve_queue(ok);
    if (ok) serve_finish(1, 3, '0, ST_OK);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_reset_mid();
    test_arb_en();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
